// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- byte-stream and consumer-side signals of the UART receive FIFO.
//   rxdata/dataok : received byte and its valid level from the uartRX stage
//   rd_en/ovf_clr : consumer read request and overflow-flag clear
//   rd_data/rd_valid/empty/full/count/overflow : FIFO read port and status
// The slave modport is the FIFO itself. The master modport is whoever drives it.
interface uart_rx_fifo_if #(
   parameter int AW = 4
);
   logic [7:0]  rxdata;
   logic        dataok;
   logic        rd_en;
   logic        ovf_clr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [AW:0] count;
   logic        overflow;

   modport slave (
      input  rxdata, dataok, rd_en, ovf_clr,
      output rd_data, rd_valid, empty, full, count, overflow
   );

   modport master (
      output rxdata, dataok, rd_en, ovf_clr,
      input  rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- DEPTH x 8 receive FIFO behind a UART receiver.
//   clk50m : 50 MHz system clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : uart_rx_fifo_if.slave
//            - a byte is written on each rising edge of dataok
//            - rd_en pops one byte per cycle; rd_data and rd_valid follow one cycle later
//            - overflow is sticky when a byte is dropped on a full FIFO
//              and is cleared by ovf_clr. A set in the same cycle wins over the clear.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                clk50m,
   input  logic                reset,
   uart_rx_fifo_if.slave       bus
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overflow_q, overflow_d;
   logic          dataok_q, dataok_d;
   logic          arm_q, arm_d;

   logic          wr_stb;
   logic          rd_acc;
   logic          wr_acc;
   logic          empty;
   logic          full;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

   // arm_q stays low until dataok has been seen low after reset. A dataok
   // level that is already high when reset releases is therefore not a write.
   assign wr_stb = bus.dataok & ~dataok_q & arm_q;
   assign rd_acc = bus.rd_en & ~empty;
   // When the FIFO is full, the write and read pointers are equal. A write in the
   // same cycle as an accepted read reuses the slot that the read is emptying.
   assign wr_acc = wr_stb & (~full | rd_acc);

   // NOTE: every _d gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;
      dataok_d   = bus.dataok;
      arm_d      = arm_q | ~bus.dataok;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end

      if (wr_acc && !rd_acc) begin
         count_d = count_q + (AW+1)'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - (AW+1)'(1);
      end

      if (wr_stb && full && !rd_acc) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk50m or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         dataok_q   <= 1'b0;
         arm_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         dataok_q   <= dataok_d;
         arm_q      <= arm_d;
      end
   end

   // NOTE: the storage array has no reset. Emptiness is tracked by count_q and the
   //       pointers, so stale contents are never visible.
   always_ff @(posedge clk50m) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= bus.rxdata;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed bench for uart_rx_fifo (DEPTH=16).
// Inputs change 1 ns after each rising edge. Outputs are sampled at that same point,
// after the edge has taken effect.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk50m = 1'b0;
   logic reset  = 1'b1;
   int   total  = 0;
   int   bad    = 0;

   uart_rx_fifo_if #(.AW(AW)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk50m (clk50m),
      .reset  (reset),
      .bus    (bus)
   );

   always #10 clk50m = ~clk50m;

   task automatic tick();
      @(posedge clk50m);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // dataok is held high for 'hold' cycles and then dropped for one cycle.
   task automatic wr_byte(input logic [7:0] b, input int hold);
      bus.rxdata = b;
      bus.dataok = 1'b1;
      repeat (hold) tick();
      bus.dataok = 1'b0;
      tick();
   endtask

   initial begin
      int max_cnt;
      bus.rxdata  = 8'h00;
      bus.dataok  = 1'b0;
      bus.rd_en   = 1'b0;
      bus.ovf_clr = 1'b0;

      // reset state
      repeat (3) tick();
      chk("rst_count", 16'(bus.count), 16'd0);
      chk("rst_empty", 16'(bus.empty), 16'd1);
      chk("rst_full", 16'(bus.full), 16'd0);
      chk("rst_ovf", 16'(bus.overflow), 16'd0);
      chk("rst_rd_valid", 16'(bus.rd_valid), 16'd0);
      chk("rst_rd_data", 16'(bus.rd_data), 16'h00);
      reset = 1'b0;
      tick();

      // two bytes, each with dataok held for 3 cycles
      wr_byte(8'h48, 3);
      chk("w1_count", 16'(bus.count), 16'd1);
      wr_byte(8'h49, 3);
      chk("w2_count", 16'(bus.count), 16'd2);
      chk("w2_empty", 16'(bus.empty), 16'd0);
      bus.rd_en = 1'b1;
      tick();
      chk("r1_valid", 16'(bus.rd_valid), 16'd1);
      chk("r1_data", 16'(bus.rd_data), 16'h48);
      chk("r1_count", 16'(bus.count), 16'd1);
      tick();
      chk("r2_valid", 16'(bus.rd_valid), 16'd1);
      chk("r2_data", 16'(bus.rd_data), 16'h49);
      chk("r2_count", 16'(bus.count), 16'd0);
      bus.rd_en = 1'b0;
      tick();
      chk("r3_valid", 16'(bus.rd_valid), 16'd0);
      chk("r3_data_hold", 16'(bus.rd_data), 16'h49);
      chk("r3_empty", 16'(bus.empty), 16'd1);

      // fill to full, drop one byte, drain in order, clear the overflow flag
      for (int i = 0; i < DEPTH; i++) wr_byte(8'(i), 1);
      chk("fill_full", 16'(bus.full), 16'd1);
      chk("fill_count", 16'(bus.count), 16'd16);
      chk("fill_ovf", 16'(bus.overflow), 16'd0);
      wr_byte(8'hAA, 1);
      chk("drop_ovf", 16'(bus.overflow), 16'd1);
      chk("drop_count", 16'(bus.count), 16'd16);
      bus.rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk($sformatf("drain_data_%0d", i), 16'(bus.rd_data), 16'(i));
         chk($sformatf("drain_valid_%0d", i), 16'(bus.rd_valid), 16'd1);
      end
      bus.rd_en = 1'b0;
      tick();
      chk("drain_empty", 16'(bus.empty), 16'd1);
      chk("drain_ovf_sticky", 16'(bus.overflow), 16'd1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("ovf_clr", 16'(bus.overflow), 16'd0);

      // full FIFO: a write and a read in the same cycle
      for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h10 + i), 1);
      chk("full2_count", 16'(bus.count), 16'd16);
      bus.rxdata = 8'h55;
      bus.dataok = 1'b1;
      bus.rd_en  = 1'b1;
      tick();
      bus.dataok = 1'b0;
      bus.rd_en  = 1'b0;
      chk("simul_data", 16'(bus.rd_data), 16'h10);
      chk("simul_count", 16'(bus.count), 16'd16);
      chk("simul_ovf", 16'(bus.overflow), 16'd0);
      tick();
      bus.rd_en = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         tick();
         chk($sformatf("simul_drain_%0d", i), 16'(bus.rd_data),
             (i == DEPTH) ? 16'h55 : 16'(8'h10 + i));
      end
      bus.rd_en = 1'b0;
      tick();
      chk("simul_empty", 16'(bus.count), 16'd0);

      // reads on an empty FIFO are ignored
      bus.rd_en = 1'b1;
      repeat (3) begin
         tick();
         chk("empty_rd_valid", 16'(bus.rd_valid), 16'd0);
         chk("empty_rd_count", 16'(bus.count), 16'd0);
      end
      chk("empty_rd_data_hold", 16'(bus.rd_data), 16'h55);
      bus.rxdata = 8'h77;
      bus.dataok = 1'b1;
      tick();
      chk("wr_rd_empty_count", 16'(bus.count), 16'd1);
      chk("wr_rd_empty_valid", 16'(bus.rd_valid), 16'd0);
      bus.dataok = 1'b0;
      tick();
      chk("wr_rd_next_valid", 16'(bus.rd_valid), 16'd1);
      chk("wr_rd_next_data", 16'(bus.rd_data), 16'h77);
      bus.rd_en = 1'b0;
      tick();

      // pointer wrap: 40 write/read pairs
      max_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         bus.rxdata = 8'(8'h80 + k);
         bus.dataok = 1'b1;
         tick();
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
         bus.dataok = 1'b0;
         bus.rd_en  = 1'b1;
         tick();
         bus.rd_en  = 1'b0;
         chk($sformatf("wrap_data_%0d", k), 16'(bus.rd_data), 16'(8'h80 + k));
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end
      chk("wrap_max_count", 16'(max_cnt), 16'd1);
      chk("wrap_ovf", 16'(bus.overflow), 16'd0);

      // reset in the middle of operation, with dataok high
      for (int i = 0; i < 5; i++) wr_byte(8'(8'hC0 + i), 1);
      chk("pre_rst_count", 16'(bus.count), 16'd5);
      bus.rxdata = 8'hEE;
      bus.dataok = 1'b1;
      reset = 1'b1;
      #1;
      chk("async_rst_count", 16'(bus.count), 16'd0);
      chk("async_rst_empty", 16'(bus.empty), 16'd1);
      tick();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("post_rst_no_wr", 16'(bus.count), 16'd0);
      bus.dataok = 1'b0;
      tick();
      chk("post_rst_low", 16'(bus.count), 16'd0);
      bus.rxdata = 8'h3C;
      bus.dataok = 1'b1;
      tick();
      bus.dataok = 1'b0;
      chk("post_rst_wr", 16'(bus.count), 16'd1);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("post_rst_rd", 16'(bus.rd_data), 16'h3C);
      chk("post_rst_empty", 16'(bus.empty), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default 4, address width; SHALL equal log2(DEPTH).
REQ-003 clk50m  input  1  system clock, 50 MHz; all logic SHALL be rising-edge clocked on it.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rxdata  input  8  received byte from the uartRX stage.
REQ-006 dataok  input  1  byte-valid level from uartRX, synchronous to clk50m; may stay high for several cycles.
REQ-007 rd_en  input  1  consumer read request, one byte per high cycle.
REQ-008 ovf_clr  input  1  clears the overflow flag.
REQ-009 rd_data  output  8  byte read from the FIFO, registered.
REQ-010 rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-011 empty  output  1  FIFO holds 0 bytes.
REQ-012 full  output  1  FIFO holds DEPTH bytes.
REQ-013 count  output  AW+1  bytes currently stored, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-015 Write strobe wr_stb SHALL be the rising edge of dataok: dataok high now, low in the previous cycle (one-flop edge detector).
REQ-016 On wr_stb with full=0 (or full=1 with an accepted read in the same cycle), rxdata sampled in that cycle SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-017 On wr_stb with full=1 and no accepted read, the byte SHALL be dropped, pointers and count unchanged, and overflow set to 1 on the next edge.
REQ-018 A read is accepted when rd_en=1 and empty=0; mem[rd_ptr] SHALL appear on rd_data with rd_valid=1 one cycle later; rd_ptr SHALL increment modulo DEPTH.
REQ-019 rd_en with empty=1 SHALL be ignored: rd_valid stays 0 and rd_data holds its previous value.
REQ-020 Simultaneous accepted write and accepted read SHALL leave count unchanged; both pointers advance.
REQ-021 Simultaneous wr_stb and rd_en when empty=1: write accepted, read ignored; count becomes 1.
REQ-022 count SHALL increment on write-only, decrement on read-only, otherwise hold; empty = (count==0), full = (count==DEPTH), both combinational from count.
REQ-023 Pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-024 overflow SHALL clear on ovf_clr=1; if set and clear coincide, set SHALL win.
REQ-025 Throughput: one write and one read per clock sustained; write-to-empty-deassert latency one cycle.
REQ-026 Storage SHALL be a DEPTH x 8 register array; memory contents need not be reset.

Reset
REQ-027 While reset=1: wr_ptr=0, rd_ptr=0, count=0, rd_data=8'h00, rd_valid=0, overflow=0, edge-detect flop=0; hence empty=1, full=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored bytes immediately; after release, the first write lands at address 0.
REQ-029 If dataok is high when reset releases, it SHALL NOT be taken as a write until it goes low and rises again.

Verification
REQ-030 Write 8'h48 then 8'h49 (dataok held 3 cycles each), then rd_en twice -> exactly two writes, count 2->0, rd_data 8'h48 then 8'h49 each with a one-cycle rd_valid pulse.
REQ-031 Write 16 bytes 8'h00..8'h0F -> full=1, count=16; 17th write 8'hAA -> dropped, overflow=1; 16 reads return 8'h00..8'h0F in order; ovf_clr -> overflow=0.
REQ-032 Full FIFO, wr_stb 8'h55 and rd_en in the same cycle -> count stays 16, overflow stays 0, 8'h55 is read last.
REQ-033 Empty FIFO, rd_en for 3 cycles -> rd_valid stays 0, count 0; wr_stb with rd_en on the same cycle -> count=1, no rd_valid.
REQ-034 Pointer wrap: 40 write/read pairs of incrementing bytes -> all read back in order, count never exceeds 1, no overflow.
REQ-035 Reset asserted with count=5 and dataok high -> count=0, empty=1 immediately; after release, no write until dataok toggles low-high.
